// File: rtl/backbone_pkg.sv
// Shared definitions for the backbone layer readers: default widths, reader FSM
// states and the ReLU / rounding requantise / saturate transform.
package backbone_pkg;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 32;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} reader_state_e;

   // The 64-bit working width is at least ACC_W_P+1 for any accumulator up to
   // 63 bits, so the rounding add can never wrap.
   function automatic logic signed [63:0] requant(
      input logic signed [63:0] x,
      input int                 shift,
      input bit                 relu_en,
      input int                 data_w
   );
      logic signed [63:0] y;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      y = x;
      if (relu_en && (y < 0)) y = '0;
      if (shift > 0) y = (y + (64'sd1 <<< (shift - 1))) >>> shift;
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (y > hi) y = hi;
      else if (y < lo) y = lo;
      return y;
   endfunction
endpackage

// File: rtl/conv1_c_bram_reader_if.sv
// BRAM read port plus requantised output stream of the conv1 C-matrix reader.
interface conv1_c_bram_reader_if #(
   parameter int DATA_W_P = backbone_pkg::DATA_W,
   parameter int ACC_W_P  = backbone_pkg::ACC_W
);
   logic                       c_rd_en;
   logic [31:0]                c_rd_addr;
   logic signed [ACC_W_P-1:0]  c_rd_data;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [DATA_W_P-1:0] out_data;
   logic [31:0]                out_m;
   logic [31:0]                out_n;
   logic                       out_last;

   modport master (
      output c_rd_en, c_rd_addr,
      input  c_rd_data,
      output out_valid, out_data, out_m, out_n, out_last,
      input  out_ready
   );

   modport slave (
      input  c_rd_en, c_rd_addr,
      output c_rd_data,
      input  out_valid, out_data, out_m, out_n, out_last,
      output out_ready
   );
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry ping-pong FIFO; head_data is registered and holds while not popped.
module stream_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         not_empty,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(do_push) - 2'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign not_empty = (count_q != 2'd0);
   assign count     = count_q;
endmodule

// File: rtl/conv1_c_bram_reader.sv
// Drains the conv1 C matrix from BRAM in raster order, requantises each word and
// streams it out with its (m,n) coordinates under valid/ready flow control.
module conv1_c_bram_reader
   import backbone_pkg::*;
#(
   parameter int M_TOTAL  = 56*56,
   parameter int N_TOTAL  = 64,
   parameter int DATA_W_P = DATA_W,
   parameter int ACC_W_P  = ACC_W,
   parameter int SHIFT    = 8,
   parameter int RELU_EN  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done,
   conv1_c_bram_reader_if.master bus
);
   localparam int TOTAL = M_TOTAL * N_TOTAL;
   localparam int PAY_W = DATA_W_P + 65;

   reader_state_e state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] m_q, m_d;
   logic [31:0] n_q, n_d;
   logic        done_q, done_d;
   logic        inflight_q, inflight_d;
   logic [31:0] tag_m_q, tag_m_d;
   logic [31:0] tag_n_q, tag_n_d;
   logic        tag_last_q, tag_last_d;

   logic                       issue, last_issue, pop;
   logic [2:0]                 occupancy;
   logic [1:0]                 fifo_count;
   logic                       fifo_valid;
   logic signed [DATA_W_P-1:0] elem;
   logic [PAY_W-1:0]           push_data, head_data;

   // Occupancy counts this cycle's pop so a full-rate stream keeps one read per cycle.
   assign pop        = fifo_valid && bus.out_ready;
   assign occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
   assign issue      = (state_q == S_RUN) && (occupancy < 3'd2);
   assign last_issue = (addr_q == 32'(TOTAL - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (issue && last_issue) state_d = S_DRAIN;
         S_DRAIN: if (!fifo_valid && !inflight_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
      bus.c_rd_en   = issue;
      bus.c_rd_addr = issue ? addr_q : 32'd0;
   end

   always_comb begin
      addr_d     = addr_q;
      m_d        = m_q;
      n_d        = n_q;
      done_d     = done_q;
      inflight_d = issue;
      tag_m_d    = tag_m_q;
      tag_n_d    = tag_n_q;
      tag_last_d = tag_last_q;
      if ((state_q == S_IDLE) && start) begin
         addr_d = 32'd0;
         m_d    = 32'd0;
         n_d    = 32'd0;
         done_d = 1'b0;
      end
      if (state_q == S_DONE) done_d = 1'b1;
      if (issue) begin
         tag_m_d    = m_q;
         tag_n_d    = n_q;
         tag_last_d = last_issue;
         addr_d     = addr_q + 32'd1;
         if (n_q == 32'(N_TOTAL - 1)) begin
            n_d = 32'd0;
            m_d = m_q + 32'd1;
         end else begin
            n_d = n_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= 32'd0;
         m_q        <= 32'd0;
         n_q        <= 32'd0;
         done_q     <= 1'b0;
         inflight_q <= 1'b0;
         tag_m_q    <= 32'd0;
         tag_n_q    <= 32'd0;
         tag_last_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         m_q        <= m_d;
         n_q        <= n_d;
         done_q     <= done_d;
         inflight_q <= inflight_d;
         tag_m_q    <= tag_m_d;
         tag_n_q    <= tag_n_d;
         tag_last_q <= tag_last_d;
      end
   end

   // Returning word is transformed on arrival and stored with the tag of its read.
   assign elem      = DATA_W_P'(requant(64'(bus.c_rd_data), SHIFT, RELU_EN != 0, DATA_W_P));
   assign push_data = {tag_last_q, tag_m_q, tag_n_q, elem};

   stream_fifo2 #(.W(PAY_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .not_empty (fifo_valid),
      .count     (fifo_count)
   );

   assign {bus.out_last, bus.out_m, bus.out_n, bus.out_data} = head_data;
   assign bus.out_valid = fifo_valid;
   assign done          = done_q;
endmodule

// File: tb/tb_conv1_c_bram_reader.sv
// Scoreboard bench: two reader instances (ReLU/shift 4 and no-ReLU/shift 8) share
// stimulus; a monitor checks each stream against an arithmetic reference model.
module tb_conv1_c_bram_reader;
   localparam int M   = 4;
   localparam int N   = 5;
   localparam int TOT = M * N;

   typedef struct {
      int data;
      int m;
      int n;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic rdy;
   int   rdy_mode;
   int   checkCount = 0;
   int   passCount  = 0;

   logic signed [31:0] mem [TOT];
   exp_t q0[$];
   exp_t q1[$];
   int   rd_cnt   [2];
   int   issued   [2];
   int   accepted [2];
   bit   stall_prev [2];
   logic signed [7:0] sd [2];
   logic [31:0] sm [2];
   logic [31:0] sn [2];
   logic        sl [2];

   logic [1:0] busy_w, done_w, v, ren, lst;
   logic signed [7:0] d [2];
   logic [31:0] om [2];
   logic [31:0] on [2];
   logic [31:0] raddr [2];

   conv1_c_bram_reader_if #(.DATA_W_P(8), .ACC_W_P(32)) ifa ();
   conv1_c_bram_reader_if #(.DATA_W_P(8), .ACC_W_P(32)) ifb ();

   conv1_c_bram_reader #(.M_TOTAL(M), .N_TOTAL(N), .DATA_W_P(8), .ACC_W_P(32),
                         .SHIFT(4), .RELU_EN(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy_w[0]), .done(done_w[0]), .bus(ifa.master));

   conv1_c_bram_reader #(.M_TOTAL(M), .N_TOTAL(N), .DATA_W_P(8), .ACC_W_P(32),
                         .SHIFT(8), .RELU_EN(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy_w[1]), .done(done_w[1]), .bus(ifb.master));

   always #5 clk = ~clk;

   assign ifa.out_ready = rdy;
   assign ifb.out_ready = rdy;
   assign v[0] = ifa.out_valid;   assign v[1] = ifb.out_valid;
   assign ren[0] = ifa.c_rd_en;   assign ren[1] = ifb.c_rd_en;
   assign lst[0] = ifa.out_last;  assign lst[1] = ifb.out_last;
   assign d[0] = ifa.out_data;    assign d[1] = ifb.out_data;
   assign om[0] = ifa.out_m;      assign om[1] = ifb.out_m;
   assign on[0] = ifa.out_n;      assign on[1] = ifb.out_n;
   assign raddr[0] = ifa.c_rd_addr;
   assign raddr[1] = ifb.c_rd_addr;

   // One-cycle-latency BRAM models sharing the same contents.
   always @(posedge clk) if (ifa.c_rd_en) ifa.c_rd_data <= mem[ifa.c_rd_addr[4:0]];
   always @(posedge clk) if (ifb.c_rd_en) ifb.c_rd_data <= mem[ifb.c_rd_addr[4:0]];

   // Reference transform: floor division by 2^shift after adding half, then clamp.
   function automatic int modelElem(input longint w, input bit relu, input int shift);
      longint x;
      longint p;
      x = w;
      if (relu && x < 0) x = 0;
      if (shift > 0) begin
         p = longint'(1) << shift;
         x = x + p / 2;
         if (x >= 0) x = x / p;
         else        x = -((-x + p - 1) / p);
      end
      if (x > 127)  x = 127;
      if (x < -128) x = -128;
      return int'(x);
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checkCount++;
      if (act == exp) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic scoreElem(input int i);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
         checkOutput($sformatf("dut%0d unexpected element", i), 1, 0);
      end else begin
         checkOutput($sformatf("dut%0d data m%0d n%0d", i, e.m, e.n), int'(d[i]), e.data);
         checkOutput($sformatf("dut%0d m", i), om[i], e.m);
         checkOutput($sformatf("dut%0d n", i), on[i], e.n);
         checkOutput($sformatf("dut%0d last m%0d n%0d", i, e.m, e.n), lst[i], e.last);
      end
   endtask

   task automatic applyStimulus();
      exp_t e;
      for (int k = 0; k < TOT; k++) begin
         e.m    = k / N;
         e.n    = k % N;
         e.last = (k == TOT - 1);
         e.data = modelElem(mem[k], 1'b1, 4);
         q0.push_back(e);
         e.data = modelElem(mem[k], 1'b0, 8);
         q1.push_back(e);
      end
      rd_cnt[0] = 0;
      rd_cnt[1] = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic waitDone();
      int cyc;
      cyc = 0;
      while (done_w != 2'b11 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("done reached", done_w, 2'b11);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("dut%0d busy after done", i), busy_w[i], 0);
         checkOutput($sformatf("dut%0d read count", i), rd_cnt[i], TOT);
      end
      checkOutput("dut0 leftover expected", q0.size(), 0);
      checkOutput("dut1 leftover expected", q1.size(), 0);
   endtask

   task automatic checkResetState();
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("dut%0d reset busy", i), busy_w[i], 0);
         checkOutput($sformatf("dut%0d reset done", i), done_w[i], 0);
         checkOutput($sformatf("dut%0d reset valid", i), v[i], 0);
         checkOutput($sformatf("dut%0d reset rd_en", i), ren[i], 0);
         checkOutput($sformatf("dut%0d reset rd_addr", i), raddr[i], 0);
         checkOutput($sformatf("dut%0d reset data", i), int'(d[i]), 0);
         checkOutput($sformatf("dut%0d reset m", i), om[i], 0);
         checkOutput($sformatf("dut%0d reset n", i), on[i], 0);
         checkOutput($sformatf("dut%0d reset last", i), lst[i], 0);
      end
   endtask

   task automatic fillRandom();
      for (int k = 0; k < TOT; k++)
         mem[k] = int'($urandom_range(0, 2097152)) - 1048576;
   endtask

   initial begin
      rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       rdy = ($urandom_range(0, 99) < 30);
            2:       rdy = 1'b0;
            default: rdy = 1'b1;
         endcase
      end
   end

   // Monitor: scoreboard pops, hold-stability, capacity and idle-address checks.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
               if (ren[i]) begin
                  rd_cnt[i]++;
                  issued[i]++;
               end else begin
                  checkOutput($sformatf("dut%0d idle rd_addr", i), raddr[i], 0);
               end
               if (stall_prev[i])
                  checkOutput($sformatf("dut%0d held output stable", i),
                              (v[i] == 1'b1 && d[i] == sd[i] && om[i] == sm[i] &&
                               on[i] == sn[i] && lst[i] == sl[i]), 1);
               if (v[i] && rdy) begin
                  accepted[i]++;
                  scoreElem(i);
               end
               if (ren[i])
                  checkOutput($sformatf("dut%0d outstanding<=2", i),
                              (issued[i] - accepted[i] <= 2), 1);
               stall_prev[i] = v[i] && !rdy;
               sd[i] = d[i];
               sm[i] = om[i];
               sn[i] = on[i];
               sl[i] = lst[i];
            end
         end
      end
   end

   initial begin
      int cyc;
      rst_n    = 1'b0;
      start    = 1'b0;
      rdy_mode = 0;
      for (int i = 0; i < 2; i++) begin
         issued[i] = 0; accepted[i] = 0; rd_cnt[i] = 0; stall_prev[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 checkResetState();
      @(posedge clk); #1 rst_n = 1'b1;

      // Ramp k*256 at full rate.
      for (int k = 0; k < TOT; k++) mem[k] = k * 256;
      applyStimulus();
      waitDone();

      // Corner words plus random data under 30% ready.
      fillRandom();
      mem[0] = -1000;
      mem[1] = 1 << 20;
      mem[2] = -(1 << 20);
      rdy_mode = 1;
      applyStimulus();
      waitDone();

      // Long back-pressure right after the first valid element.
      fillRandom();
      rdy_mode = 2;
      applyStimulus();
      cyc = 0;
      while (v[0] == 1'b0 && cyc < 50) begin @(negedge clk); cyc++; end
      checkOutput("first valid seen", v[0], 1);
      repeat (20) @(negedge clk);
      checkOutput("dut0 reads during stall<=2", rd_cnt[0] <= 2, 1);
      checkOutput("dut1 reads during stall<=2", rd_cnt[1] <= 2, 1);
      rdy_mode = 0;
      waitDone();

      // Reset in the middle of a run, then a fresh drain.
      fillRandom();
      rdy_mode = 1;
      applyStimulus();
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 checkResetState();
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         issued[i] = 0; accepted[i] = 0; stall_prev[i] = 1'b0;
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("post-reset valid", v, 2'b00);
      checkOutput("post-reset busy", busy_w, 2'b00);
      fillRandom();
      applyStimulus();
      waitDone();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/conv1_c_bram_reader.md
CONV1_C_BRAM_READER -- requirements
Module: conv1_c_bram_reader

Interface
REQ-001 SHALL have parameter M_TOTAL, default 56*56, meaning number of C rows (output pixels).
REQ-002 SHALL have parameter N_TOTAL, default 64, meaning number of C columns (output channels).
REQ-003 SHALL have parameter DATA_W_P, default DATA_W, meaning output element width.
REQ-004 SHALL have parameter ACC_W_P, default ACC_W, meaning BRAM word (accumulator) width.
REQ-005 SHALL have parameter SHIFT, default 8, meaning requant right-shift amount (0 allowed).
REQ-006 SHALL have parameter RELU_EN, default 1, meaning clamp negatives to zero before requant.
REQ-007 SHALL have ports: clk input 1 clock; rst_n input 1 async active-low reset.
REQ-008 SHALL have ports: start input 1 begin drain; busy output 1 run in progress; done output 1 sticky completion.
REQ-009 SHALL have ports: c_rd_en output 1 BRAM read strobe; c_rd_addr output int word address; c_rd_data input ACC_W_P signed BRAM read data.
REQ-010 SHALL have ports: out_valid output 1; out_ready input 1; out_data output DATA_W_P signed; out_m output int row index; out_n output int column index; out_last output 1 final element.

Function
REQ-011 SHALL read C words at addr = m*N_TOTAL + n in raster order: n fastest, m slowest, m in 0..M_TOTAL-1, n in 0..N_TOTAL-1.
REQ-012 SHALL treat BRAM read latency as exactly 1 cycle: c_rd_data valid the cycle after c_rd_en=1.
REQ-013 SHALL use FSM states S_IDLE, S_RUN, S_DRAIN, S_DONE.
REQ-014 S_IDLE: start=1 -> clear done, reset address counter to 0, go S_RUN; start ignored in every other state.
REQ-015 S_RUN: assert c_rd_en only when (FIFO occupancy + reads in flight) < 2; after issuing the last address (M_TOTAL*N_TOTAL-1), go S_DRAIN.
REQ-016 SHALL capture returning data into a 2-entry FIFO with the element's (m,n); no read is ever dropped or duplicated under any out_ready pattern.
REQ-017 S_DRAIN: when the FIFO is empty and no read is in flight -> S_DONE; S_DONE: set done=1 and go S_IDLE in one cycle.
REQ-018 Output handshake: element transfers when out_valid & out_ready; out_valid, out_data, out_m, out_n SHALL stay stable while out_valid=1 & out_ready=0.
REQ-019 out_valid SHALL equal FIFO non-empty; first out_valid no earlier than 2 cycles after start accepted.
REQ-020 With out_ready held 1, SHALL sustain 1 element per cycle after the first.
REQ-021 Transform: x = c_rd_data; if RELU_EN and x<0 then x=0; if SHIFT>0 then x = (x + 2^(SHIFT-1)) >>> SHIFT (arithmetic); saturate to [-2^(DATA_W_P-1), 2^(DATA_W_P-1)-1]. Intermediate width SHALL be ACC_W_P+1 to avoid rounding overflow.
REQ-022 out_last SHALL be 1 exactly on the element with m=M_TOTAL-1, n=N_TOTAL-1.
REQ-023 busy SHALL be 1 in S_RUN and S_DRAIN, 0 otherwise.
REQ-024 c_rd_addr SHALL be 0 whenever c_rd_en=0.

Reset
REQ-025 On rst_n=0, asynchronously: state S_IDLE, done=0, busy=0, c_rd_en=0, c_rd_addr=0, out_valid=0, out_data=0, out_m=0, out_n=0, out_last=0, FIFO emptied, in-flight flag cleared.
REQ-026 Reset mid-run SHALL abandon the drain; data returning from BRAM after reset release SHALL be ignored.

Structure
REQ-027 The requant/ReLU/saturate function and state enum SHALL live in backbone_pkg (shared with later layer readers); DATA_W/ACC_W come from backbone_pkg.
REQ-028 The 2-entry output FIFO SHALL be a sub-module named stream_fifo2 (parameterised payload width).

Verification
REQ-029 M_TOTAL=2,N_TOTAL=3, BRAM preloaded addr k = k*256, SHIFT=8, out_ready=1 -> out_data 0,1,2,3,4,5, out_last on 6th, done=1, 6 reads total.
REQ-030 Word -1000, RELU_EN=1 -> 0; RELU_EN=0, SHIFT=8 -> -4 (=(-1000+128)>>>8).
REQ-031 Word 2^20, SHIFT=4, DATA_W_P=8 -> 127; word -2^20, RELU_EN=0 -> -128.
REQ-032 out_ready random 30% duty, full 3136x64 drain -> 200704 elements in order, matching golden, no c_rd_en while FIFO+in-flight=2.
REQ-033 out_ready=0 for 20 cycles after first valid -> out_* stable, c_rd_en issued at most twice total, then resume losslessly.
REQ-034 rst_n pulsed low mid-S_RUN -> all outputs at reset values; subsequent start drains from addr 0 correctly.
